// File: rtl/udp_tx_framer.sv
// udp_tx_framer: buffers kernel payload words and emits Ethernet/IPv4/UDP frames and ARP replies on AXI-S (optional UDP_TX_FLUSH_TIMEOUT_EN)
module udp_tx_framer #(
  parameter int PAYLOAD_WORDS  = 16,
  parameter int FIFO_DEPTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        kernel_clk,
  input  logic        kernel_resetn,
  input  logic        k_valid,
  input  logic [63:0] k_data,
  output logic        k_ready,
  input  logic [47:0] fpga_mac_adr,
  input  logic [47:0] host_mac_adr,
  input  logic [31:0] fpga_ip_adr,
  input  logic [31:0] host_ip_adr,
  input  logic [15:0] fpga_udp_port,
  input  logic [15:0] host_udp_port,
  input  logic        arp_trigger,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic [63:0] tx_tdata,
  output logic [7:0]  tx_tkeep,
  output logic        tx_tlast,
  output logic [31:0] tx_pkt_count,
  output logic [3:0]  tx_sm_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW = AW + 3;
  localparam logic [CNTW-1:0] PW = CNTW'(PAYLOAD_WORDS);
  typedef enum logic [3:0] {IDLE, CSUM, HDR, PAYLOAD, ARP} state_t;
  state_t state;
  logic [63:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0] count, count_nx;
  logic [CW-1:0] beat, n;
  logic [15:0] seq, ip_len, udp_len, csum, ip_len_c, f2;
  logic [19:0] sum;
  logic [16:0] f1;
  logic arp_pending, wr, pop, ld, hs_last, timeout;
  logic [0:5][63:0] hdr, arp;
  assign wr = k_valid & k_ready;
  assign ld = ~tx_tvalid | tx_tready;
  assign hs_last = tx_tvalid & tx_tready & tx_tlast;
  assign pop = (state == PAYLOAD) && ld && (beat < n);
  assign count_nx = count + CNTW'(wr) - CNTW'(pop);
  assign tx_sm_state = state;
  assign ip_len_c = 16'(32'd34 + 32'd8 * 32'(n));
  assign sum = 20'h04500 + 20'(ip_len_c) + 20'h04000 + 20'h04011
             + 20'(fpga_ip_adr[31:16]) + 20'(fpga_ip_adr[15:0])
             + 20'(host_ip_adr[31:16]) + 20'(host_ip_adr[15:0]);
  assign f1 = 17'(sum[15:0]) + 17'(sum[19:16]);
  assign f2 = f1[15:0] + 16'(f1[16]);
  assign hdr = {host_mac_adr, fpga_mac_adr, 16'h0800, 8'h45, 8'h00,
                ip_len, 16'h0000, 16'h4000, 8'h40, 8'h11,
                csum, fpga_ip_adr, host_ip_adr,
                fpga_udp_port, host_udp_port, udp_len,
                16'h0000, seq, 32'h0};
  assign arp = {host_mac_adr, fpga_mac_adr, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                16'h0002, fpga_mac_adr, fpga_ip_adr, host_mac_adr, host_ip_adr, 48'h0};
`ifdef UDP_TX_FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  assign timeout = idle_cnt == TW'(TIMEOUT_CYCLES);
  // count quiet cycles while a partial payload sits in the buffer
  always_ff @(posedge kernel_clk or negedge kernel_resetn)
    if (!kernel_resetn) idle_cnt <= '0;
    else if (wr || count == '0 || count >= PW) idle_cnt <= '0;
    else if (!timeout) idle_cnt <= idle_cnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  // payload storage, written by the kernel
  always_ff @(posedge kernel_clk)
    if (wr) mem[wr_ptr] <= k_data;
  // buffer pointers, occupancy and registered ready derived from next occupancy
  always_ff @(posedge kernel_clk or negedge kernel_resetn)
    if (!kernel_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      k_ready <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count_nx;
      k_ready <= count_nx != CNTW'(FIFO_DEPTH);
    end
  // frame sequencer: next beat is loaded whenever the output slot is empty or being consumed
  always_ff @(posedge kernel_clk or negedge kernel_resetn)
    if (!kernel_resetn) begin
      state <= IDLE;
      beat <= '0;
      n <= '0;
      seq <= '0;
      ip_len <= '0;
      udp_len <= '0;
      csum <= '0;
      arp_pending <= 1'b0;
      tx_tvalid <= 1'b0;
      tx_tdata <= '0;
      tx_tkeep <= '0;
      tx_tlast <= 1'b0;
      tx_pkt_count <= '0;
    end else begin
      arp_pending <= arp_trigger | (arp_pending & ~(state == ARP && hs_last));
      case (state)
        IDLE: begin
          beat <= '0;
          if (arp_pending) state <= ARP;
          else if (count >= PW) begin
            n <= CW'(PAYLOAD_WORDS);
            state <= CSUM;
          end else if (timeout) begin
            n <= CW'(count);
            state <= CSUM;
          end
        end
        CSUM: begin
          ip_len <= ip_len_c;
          udp_len <= 16'(32'd14 + 32'd8 * 32'(n));
          csum <= ~f2;
          state <= HDR;
        end
        HDR: if (ld) begin
          tx_tvalid <= 1'b1;
          tx_tdata <= hdr[beat[2:0]];
          tx_tkeep <= 8'hFF;
          tx_tlast <= 1'b0;
          beat <= (beat == CW'(5)) ? '0 : beat + 1'b1;
          state <= (beat == CW'(5)) ? PAYLOAD : HDR;
        end
        PAYLOAD: if (hs_last) begin
          tx_tvalid <= 1'b0;
          tx_tlast <= 1'b0;
          tx_pkt_count <= tx_pkt_count + 32'd1;
          seq <= seq + 16'd1;
          state <= IDLE;
        end else if (pop) begin
          tx_tvalid <= 1'b1;
          tx_tdata <= mem[rd_ptr];
          tx_tlast <= beat == n - 1'b1;
          beat <= beat + 1'b1;
        end
        ARP: if (hs_last) begin
          tx_tvalid <= 1'b0;
          tx_tlast <= 1'b0;
          state <= IDLE;
        end else if (ld && beat < CW'(6)) begin
          tx_tvalid <= 1'b1;
          tx_tdata <= arp[beat[2:0]];
          tx_tkeep <= (beat == CW'(5)) ? 8'hC0 : 8'hFF;
          tx_tlast <= beat == CW'(5);
          beat <= beat + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_udp_tx_framer.sv
// tb_udp_tx_framer: directed self-checking bench for udp_tx_framer
module tb_udp_tx_framer;
  logic        kernel_clk;
  logic        kernel_resetn;
  logic        k_valid;
  logic [63:0] k_data;
  logic        k_ready;
  logic [47:0] fpga_mac_adr, host_mac_adr;
  logic [31:0] fpga_ip_adr, host_ip_adr;
  logic [15:0] fpga_udp_port, host_udp_port;
  logic        arp_trigger;
  logic        tx_tvalid;
  logic        tx_tready;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tkeep;
  logic        tx_tlast;
  logic [31:0] tx_pkt_count;
  logic [3:0]  tx_sm_state;
  int checks = 0;
  int errors = 0;
  logic rnd_en = 1'b0;
  logic rdy_val = 1'b1;
  logic [63:0] bd[$];
  logic [7:0]  bk[$];
  logic        bl[$];

  udp_tx_framer dut (
    .kernel_clk(kernel_clk), .kernel_resetn(kernel_resetn),
    .k_valid(k_valid), .k_data(k_data), .k_ready(k_ready),
    .fpga_mac_adr(fpga_mac_adr), .host_mac_adr(host_mac_adr),
    .fpga_ip_adr(fpga_ip_adr), .host_ip_adr(host_ip_adr),
    .fpga_udp_port(fpga_udp_port), .host_udp_port(host_udp_port),
    .arp_trigger(arp_trigger),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast),
    .tx_pkt_count(tx_pkt_count), .tx_sm_state(tx_sm_state)
  );

  initial begin
    kernel_clk = 1'b0;
    forever #5 kernel_clk = ~kernel_clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    tx_tready = 1'b0;
    forever begin
      @(posedge kernel_clk);
      #1 tx_tready = rnd_en ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  initial begin
    logic stall;
    logic [63:0] pd;
    logic [9:0] pc;
    stall = 1'b0;
    pd = '0;
    pc = '0;
    forever begin
      @(negedge kernel_clk);
      if (!kernel_resetn) stall = 1'b0;
      else begin
        if (stall) begin
          check("hold_data", tx_tdata, pd);
          check("hold_ctrl", {tx_tvalid, tx_tlast, tx_tkeep}, pc);
        end
        if (tx_tvalid && tx_tready) begin
          bd.push_back(tx_tdata);
          bk.push_back(tx_tkeep);
          bl.push_back(tx_tlast);
        end
        stall = tx_tvalid && !tx_tready;
        pd = tx_tdata;
        pc = {tx_tvalid, tx_tlast, tx_tkeep};
      end
    end
  end

  function automatic logic [63:0] hexp(input int i, input logic [15:0] sq);
    case (i)
      0: return 64'hAABBCCDDEEFF0011;
      1: return 64'h2233445508004500;
      2: return 64'h00A2000040004011;
      3: return 64'hB8F7C0A80002C0A8;
      4: return 64'h000112345678008E;
      default: return {16'h0000, sq, 32'h0};
    endcase
  endfunction

  task automatic push(input logic [63:0] w);
    int c = 0;
    k_data = w;
    k_valid = 1'b1;
    @(negedge kernel_clk);
    while (!k_ready && c < 2000) begin
      @(negedge kernel_clk);
      c++;
    end
    if (c >= 2000) check("push_ready", k_ready, 1);
    @(posedge kernel_clk);
    #1 k_valid = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n);
    int c = 0;
    while (bd.size() < n && c < 3000) begin
      @(negedge kernel_clk);
      c++;
    end
    repeat (40) @(negedge kernel_clk);
    check($sformatf("%s beats", tag), bd.size(), n);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [15:0] sq, input logic [63:0] w0);
    int lp = -1;
    int nl = 0;
    int kb = 0;
    for (int i = 0; i < 6; i++)
      check($sformatf("%s hdr%0d", tag, i), bd[base+i], hexp(i, sq));
    for (int i = 0; i < 16; i++)
      check($sformatf("%s pay%0d", tag, i), bd[base+6+i], w0 + 64'(i));
    for (int i = 0; i < 22; i++) begin
      if (bl[base+i]) begin
        nl++;
        if (lp < 0) lp = i;
      end
      if (bk[base+i] != 8'hFF) kb++;
    end
    check($sformatf("%s last_pos", tag), lp, 21);
    check($sformatf("%s last_cnt", tag), nl, 1);
    check($sformatf("%s keep_bad", tag), kb, 0);
  endtask

  task automatic do_reset;
    kernel_resetn = 1'b0;
    repeat (3) @(negedge kernel_clk);
    @(posedge kernel_clk);
    #1 kernel_resetn = 1'b1;
    repeat (2) @(posedge kernel_clk);
    #1;
  endtask

  initial begin
    int c;
    kernel_resetn = 1'b0;
    k_valid = 1'b0;
    k_data = '0;
    arp_trigger = 1'b0;
    fpga_mac_adr = 48'h001122334455;
    host_mac_adr = 48'hAABBCCDDEEFF;
    fpga_ip_adr = 32'hC0A80002;
    host_ip_adr = 32'hC0A80001;
    fpga_udp_port = 16'h1234;
    host_udp_port = 16'h5678;
    repeat (3) @(negedge kernel_clk);
    check("rst_tvalid", tx_tvalid, 0);
    check("rst_kready", k_ready, 0);
    check("rst_pkt", tx_pkt_count, 0);
    check("rst_state", tx_sm_state, 0);
    check("rst_out", {tx_tdata[53:0], tx_tkeep, tx_tlast}, 0);
    @(posedge kernel_clk);
    #1 kernel_resetn = 1'b1;
    repeat (2) @(negedge kernel_clk);
    check("kready_after_rst", k_ready, 1);
    @(posedge kernel_clk);
    #1;

    bd.delete(); bk.delete(); bl.delete();
    for (int i = 1; i <= 16; i++) push(64'(i));
    wait_beats("t1", 22);
    check_frame("t1", 0, 16'd0, 64'd1);
    check("t1 pkt", tx_pkt_count, 1);

    @(posedge kernel_clk);
    #1 rnd_en = 1'b1;
    bd.delete(); bk.delete(); bl.delete();
    for (int i = 0; i < 16; i++) push(64'hDEADBEEF00000100 + 64'(i));
    wait_beats("t2", 22);
    rnd_en = 1'b0;
    rdy_val = 1'b1;
    check_frame("t2", 0, 16'd1, 64'hDEADBEEF00000100);
    check("t2 pkt", tx_pkt_count, 2);

    @(posedge kernel_clk);
    #1;
    bd.delete(); bk.delete(); bl.delete();
    for (int i = 0; i < 16; i++) push(64'h300 + 64'(i));
    c = 0;
    while (tx_sm_state != 4'd3 && c < 200) begin
      @(negedge kernel_clk);
      c++;
    end
    check("t3 reach_payload", tx_sm_state, 3);
    repeat (3) begin
      @(posedge kernel_clk);
      #1 arp_trigger = 1'b1;
      @(posedge kernel_clk);
      #1 arp_trigger = 1'b0;
    end
    wait_beats("t3", 28);
    check_frame("t3", 0, 16'd2, 64'h300);
    check("t3 arp0", bd[22], 64'hAABBCCDDEEFF0011);
    check("t3 arp1", bd[23], 64'h2233445508060001);
    check("t3 arp2", bd[24], 64'h0800060400020011);
    check("t3 arp3", bd[25], 64'h22334455C0A80002);
    check("t3 arp4", bd[26], 64'hAABBCCDDEEFFC0A8);
    check("t3 arp5", bd[27], 64'h0001000000000000);
    check("t3 arp keep0", bk[22], 8'hFF);
    check("t3 arp keep5", bk[27], 8'hC0);
    check("t3 arp last4", bl[26], 0);
    check("t3 arp last5", bl[27], 1);
    check("t3 pkt", tx_pkt_count, 3);

    @(posedge kernel_clk);
    #1 rdy_val = 1'b0;
    @(posedge kernel_clk);
    #1;
    bd.delete(); bk.delete(); bl.delete();
    for (int i = 0; i < 64; i++) push(64'h1000 + 64'(i));
    @(negedge kernel_clk);
    check("t4 full_kready", k_ready, 0);
    @(posedge kernel_clk);
    #1 k_data = 64'h999;
    k_valid = 1'b1;
    repeat (5) @(negedge kernel_clk);
    check("t4 full_hold", k_ready, 0);
    @(posedge kernel_clk);
    #1 k_valid = 1'b0;
    rdy_val = 1'b1;
    wait_beats("t4", 88);
    for (int f = 0; f < 4; f++)
      check_frame($sformatf("t4f%0d", f), 22 * f, 16'(3 + f), 64'h1000 + 64'(16 * f));
    check("t4 pkt", tx_pkt_count, 7);

    @(posedge kernel_clk);
    #1;
    for (int i = 0; i < 16; i++) push(64'h4000 + 64'(i));
    c = 0;
    while (!(tx_tvalid && tx_tdata == 64'hB8F7C0A80002C0A8) && c < 200) begin
      @(negedge kernel_clk);
      c++;
    end
    check("t5 reach_hdr3", tx_tdata, 64'hB8F7C0A80002C0A8);
    kernel_resetn = 1'b0;
    #1;
    check("t5 tvalid_drop", tx_tvalid, 0);
    check("t5 state_idle", tx_sm_state, 0);
    check("t5 pkt_clr", tx_pkt_count, 0);
    repeat (2) @(negedge kernel_clk);
    @(posedge kernel_clk);
    #1 kernel_resetn = 1'b1;
    repeat (2) @(posedge kernel_clk);
    #1;
    bd.delete(); bk.delete(); bl.delete();
    repeat (20) @(negedge kernel_clk);
    check("t5 no_resume", bd.size(), 0);
    @(posedge kernel_clk);
    #1;
    for (int i = 0; i < 16; i++) push(64'h5000 + 64'(i));
    wait_beats("t5", 22);
    check_frame("t5", 0, 16'd0, 64'h5000);
    check("t5 pkt", tx_pkt_count, 1);

    @(posedge kernel_clk);
    #1;
    bd.delete(); bk.delete(); bl.delete();
    for (int i = 0; i < 3; i++) push(64'h6000 + 64'(i));
`ifdef UDP_TX_FLUSH_TIMEOUT_EN
    wait_beats("t6", 9);
    check("t6 iplen", bd[2], 64'h003A000040004011);
    check("t6 csum", bd[3], 64'hB95FC0A80002C0A8);
    check("t6 udplen", bd[4], 64'h000112345678003A - 64'h14);
    check("t6 pay2", bd[8], 64'h6002);
    check("t6 last", bl[8], 1);
    check("t6 pkt", tx_pkt_count, 2);
`else
    repeat (1100) @(negedge kernel_clk);
    check("t6 partial_wait", bd.size(), 0);
    @(posedge kernel_clk);
    #1;
    for (int i = 3; i < 16; i++) push(64'h6000 + 64'(i));
    wait_beats("t6", 22);
    check_frame("t6", 0, 16'd1, 64'h6000);
    check("t6 pkt", tx_pkt_count, 2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/udp_tx_framer.md
Name: udp_tx_framer

Overview:
Kernel-side transmit framer for the UDP offload engine, the counterpart of the RX decoder.
- Buffers 64-bit payload words from the kernel AVST stream.
- Wraps them in Ethernet/IPv4/UDP headers and emits frames on a 64-bit AXI-S stream toward the TX clock-crossing FIFO and MAC.
- Inserts ARP replies when the RX path flags an ARP request.

Parameters:
PAYLOAD_WORDS, 16, 64-bit payload words per UDP frame (1..FIFO_DEPTH)
FIFO_DEPTH, 64, payload buffer depth in words (power of 2)
TIMEOUT_CYCLES, 1024, idle cycles before partial flush (used only with the optional feature)

Ports:
kernel_clk  in  1  clock
kernel_resetn  in  1  asynchronous, active-low reset
k_valid  in  1  kernel payload valid
k_data  in  64  kernel payload word
k_ready  out  1  buffer can accept a word
fpga_mac_adr  in  48  local MAC address
host_mac_adr  in  48  destination MAC address
fpga_ip_adr  in  32  local IPv4 address
host_ip_adr  in  32  destination IPv4 address
fpga_udp_port  in  16  UDP source port
host_udp_port  in  16  UDP destination port
arp_trigger  in  1  single-cycle pulse, already synchronised to kernel_clk
tx_tvalid  out  1  AXI-S valid
tx_tready  in  1  AXI-S ready
tx_tdata  out  64  frame data; [63:56] is the first byte on the wire
tx_tkeep  out  8  byte enables; bit7 maps to [63:56]
tx_tlast  out  1  last beat of frame
tx_pkt_count  out  32  UDP frames sent (wraps)
tx_sm_state  out  4  current FSM state, for status registers

Behaviour:
- Reset values: all outputs 0; FIFO empty; sequence counter 0; ARP pending flag 0.
- Control inputs are quasi-static. They are sampled in CSUM and must not change mid-frame.

Kernel side:
- k_ready = FIFO not full.
- A word is written when k_valid & k_ready. Zero bubbles at full throughput.

AXI-S side:
- Once tx_tvalid is asserted, tdata, tkeep and tlast hold until tx_tready is seen.
- A beat advances only on tx_tvalid & tx_tready. Back-to-back beats are allowed.

ARP handling:
- arp_trigger sets arp_pending. Multiple triggers coalesce into one pending reply.
- arp_pending is cleared on the last-beat handshake of the ARP frame.

FSM states:
- IDLE:
  - If arp_pending, go to ARP.
  - Else if FIFO count >= PAYLOAD_WORDS, go to CSUM.
  - ARP has priority. It is never inserted mid-frame.
- CSUM: one cycle.
  - Register the lengths: UDP length = 14 + 8N, IP total length = 34 + 8N (N = words in this frame).
  - Register the IPv4 header checksum: one's-complement sum of 0x4500, total length, 0x0000, 0x4000, 0x4011, and the four 16-bit halves of the source and destination IPs; fold carries twice; invert.
  - Go to HDR.
- HDR: 6 beats, tkeep = 0xFF, indexed by a beat counter.
  - Beat 0: host_mac, fpga_mac[47:32].
  - Beat 1: fpga_mac[31:0], 0x0800, 0x45, 0x00.
  - Beat 2: IP length, 0x0000, 0x4000, 0x40, 0x11.
  - Beat 3: IP checksum, fpga_ip, host_ip[31:16].
  - Beat 4: host_ip[15:0], source port, destination port, UDP length.
  - Beat 5: 0x0000 (UDP checksum), sequence number[15:0], 32'h0.
  - Then go to PAYLOAD.
- PAYLOAD: N beats popped from the FIFO in order.
  - tlast on beat N-1.
  - On the final handshake: tx_pkt_count++, sequence number++ (16-bit wrap), go to IDLE.
- ARP: 6 beats.
  - Fields, in order: host_mac, fpga_mac, 0x0806, 0x0001, 0x0800, 0x06, 0x04, 0x0002, fpga_mac, fpga_ip, host_mac, host_ip.
  - Beats 0-4 have tkeep = 0xFF.
  - Beat 5 has tkeep = 0xC0 and tlast = 1. Unused bytes are 0.
  - Go to IDLE.

Boundary conditions:
- FIFO full: k_ready = 0. No overwrite.
- Simultaneous FIFO write and pop: count unchanged.
- A frame starts only when all payload is present, so tx_tvalid never drops mid-frame.
- arp_trigger during a UDP frame is latched and served in the next IDLE.
- Async reset mid-frame: tx_tvalid drops immediately, FIFO is flushed, FSM returns to IDLE, and no partial frame resumes.

Optional Feature:
UDP_TX_FLUSH_TIMEOUT_EN
- Defined:
  - An idle counter counts cycles with the FIFO non-empty, count < PAYLOAD_WORDS, and no k write. It resets on any write.
  - At TIMEOUT_CYCLES, IDLE goes to CSUM with N = current FIFO count. Lengths and checksum use that N.
- Undefined: the counter is absent, and partial payloads wait indefinitely for PAYLOAD_WORDS.

Test Plan:
1. Frame format: fpga_ip = C0A8_0002, host_ip = C0A8_0001, PAYLOAD_WORDS = 16; push words 1..16 with tready held 1.
   - Required: 22 beats total.
   - Beat 2 [63:48] = 0x00A2.
   - Beat 3 [63:48] = 0xB8F7.
   - Beat 4 [15:0] = 0x008E.
   - Payload beats = 1..16 in order; tlast only on beat 21.
   - tx_pkt_count = 1.
2. Backpressure: toggle tready randomly during a frame.
   - Required: data stable while stalled, no lost or duplicated beats, sequence field increments 0 → 1 on the second frame.
3. ARP: pulse arp_trigger three times during PAYLOAD.
   - Required: exactly one ARP frame right after that frame's tlast; 6 beats; beat 5 tkeep = 0xC0; bytes 0x0806 present.
4. FIFO full: hold tready = 0 and push 64 words.
   - Required: k_ready = 0 after the 64th word; word 65 not accepted.
5. Reset mid-frame: assert kernel_resetn = 0 at header beat 3.
   - Required: tvalid = 0 immediately; after release, the next frame starts at beat 0 with sequence 0.
6. With UDP_TX_FLUSH_TIMEOUT_EN: push 3 words, then idle 1024 cycles.
   - Required: 9-beat frame; IP length = 0x003A; UDP length = 0x0026.
